// File: rtl/axi4_burst_slave_mem.sv
// -----------------------------------------------------------------------------
// axi4_burst_slave_mem
//   AXI4 burst slave backed by a DEPTH x DATA_WIDTH on-chip memory.
//   Independent write (WR_IDLE/WR_DATA/WR_RESP) and read (RD_IDLE/RD_DATA)
//   engines, one outstanding burst per direction. FIXED, INCR and WRAP bursts
//   are supported; reserved burst type, wrong size, illegal WRAP length and
//   out-of-range word indices return SLVERR with writes suppressed / read
//   data forced to zero.
//
// Ports
//   i_w_aclk, i_w_areset       clock, synchronous active-high reset
//   i_w_aw*/o_w_awready        write address channel
//   i_w_w*/o_w_wready          write data channel
//   o_w_b*/i_w_bready          write response channel
//   i_w_ar*/o_w_arready        read address channel
//   o_w_r*/i_w_rready          read data channel
// -----------------------------------------------------------------------------
module axi4_burst_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 1024
) (
    input  logic                    i_w_aclk,
    input  logic                    i_w_areset,
    // AW
    input  logic                    i_w_awvalid,
    output logic                    o_w_awready,
    input  logic [ADDR_WIDTH-1:0]   i_w_awaddr,
    input  logic [ID_WIDTH-1:0]     i_w_awid,
    input  logic [7:0]              i_w_awlen,
    input  logic [2:0]              i_w_awsize,
    input  logic [1:0]              i_w_awburst,
    // W
    input  logic                    i_w_wvalid,
    output logic                    o_w_wready,
    input  logic [DATA_WIDTH-1:0]   i_w_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_w_wstrb,
    input  logic                    i_w_wlast,
    // B
    output logic                    o_w_bvalid,
    input  logic                    i_w_bready,
    output logic [1:0]              o_w_bresp,
    output logic [ID_WIDTH-1:0]     o_w_bid,
    // AR
    input  logic                    i_w_arvalid,
    output logic                    o_w_arready,
    input  logic [ADDR_WIDTH-1:0]   i_w_araddr,
    input  logic [ID_WIDTH-1:0]     i_w_arid,
    input  logic [7:0]              i_w_arlen,
    input  logic [2:0]              i_w_arsize,
    input  logic [1:0]              i_w_arburst,
    // R
    output logic                    o_w_rvalid,
    input  logic                    i_w_rready,
    output logic [DATA_WIDTH-1:0]   o_w_rdata,
    output logic [1:0]              o_w_rresp,
    output logic [ID_WIDTH-1:0]     o_w_rid,
    output logic                    o_w_rlast
);

    localparam int unsigned STRB_W     = DATA_WIDTH / 8;
    localparam int          BYTE_SHIFT = $clog2(STRB_W);
    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_DATA}          rd_state_t;

    // Next beat address. INCR increments only the in-range word-index bits so
    // the index wraps modulo DEPTH; WRAP uses len (1/3/7/15) as the wrap mask.
    function automatic logic [ADDR_WIDTH-1:0] f_next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] word;
        logic [ADDR_WIDTH-1:0] mask;
        word = addr >> BYTE_SHIFT;
        mask = (burst == BURST_WRAP) ? ADDR_WIDTH'(len) : IDX_MASK;
        if (burst == BURST_FIXED) begin
            return addr;
        end
        return ((word & ~mask) | ((word + ADDR_WIDTH'(1)) & mask)) << BYTE_SHIFT;
    endfunction

    function automatic logic f_burst_bad(
        input logic [1:0] burst,
        input logic [2:0] size,
        input logic [7:0] len
    );
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (size != 3'(BYTE_SHIFT)) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic f_oob(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> (BYTE_SHIFT + IDX_W)) != '0;
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------ write
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_next;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_awlen;
    logic [1:0]            r_awburst;
    logic [7:0]            r_wbeat;
    logic                  r_wbad;
    logic                  r_werr;

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wlast_exp;
    logic                  w_wbeat_oob;
    logic                  w_wbeat_err;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_widx;

    assign w_aw_hs     = i_w_awvalid && w_awready;
    assign w_w_hs      = i_w_wvalid && w_wready;
    assign w_wlast_exp = (r_wbeat == r_awlen);
    assign w_wbeat_oob = f_oob(r_waddr);
    assign w_wbeat_err = w_wbeat_oob || (i_w_wlast != w_wlast_exp);
    assign w_mem_we    = w_w_hs && !r_wbad && !w_wbeat_oob;
    assign w_widx      = r_waddr[BYTE_SHIFT +: IDX_W];

    // Handshake-visible outputs are gated by reset so they read 0 during the
    // reset cycle itself, not just after the first reset edge.
    always_comb begin
        w_wr_next = r_wr_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_wr_state)
            WR_IDLE: begin
                w_awready = !i_w_areset;
                if (i_w_awvalid && w_awready) w_wr_next = WR_DATA;
            end
            WR_DATA: begin
                w_wready = !i_w_areset;
                // Beat count, not wlast, ends the burst.
                if (i_w_wvalid && w_wready && w_wlast_exp) w_wr_next = WR_RESP;
            end
            WR_RESP: begin
                w_bvalid = !i_w_areset;
                if (i_w_bready && w_bvalid) w_wr_next = WR_IDLE;
            end
            default: w_wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge i_w_aclk) begin
        if (i_w_areset) begin
            r_wr_state <= WR_IDLE;
            r_awid     <= '0;
            r_waddr    <= '0;
            r_awlen    <= '0;
            r_awburst  <= '0;
            r_wbeat    <= '0;
            r_wbad     <= 1'b0;
            r_werr     <= 1'b0;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) begin
                r_awid    <= i_w_awid;
                r_waddr   <= i_w_awaddr;
                r_awlen   <= i_w_awlen;
                r_awburst <= i_w_awburst;
                r_wbeat   <= '0;
                r_wbad    <= f_burst_bad(i_w_awburst, i_w_awsize, i_w_awlen);
                r_werr    <= f_burst_bad(i_w_awburst, i_w_awsize, i_w_awlen);
            end
            if (w_w_hs) begin
                r_waddr <= f_next_addr(r_waddr, r_awlen, r_awburst);
                r_wbeat <= r_wbeat + 8'd1;
                r_werr  <= r_werr | w_wbeat_err;
            end
        end
    end

    assign o_w_awready = w_awready;
    assign o_w_wready  = w_wready;
    assign o_w_bvalid  = w_bvalid;
    assign o_w_bresp   = (w_bvalid && r_werr) ? RESP_SLVERR : RESP_OKAY;
    assign o_w_bid     = w_bvalid ? r_awid : '0;

    // ------------------------------------------------------------------- read
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_next;
    logic [ID_WIDTH-1:0]   r_arid;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_arlen;
    logic [1:0]            r_arburst;
    logic [7:0]            r_rbeat;
    logic                  r_rbad;
    logic                  r_rerr;
    logic [DATA_WIDTH-1:0] r_rdata_raw;

    logic                  w_arready;
    logic                  w_rvalid;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_ar_bad;
    logic                  w_rlast_beat;
    logic                  w_rload_en;
    logic                  w_rload_err;
    logic [ADDR_WIDTH-1:0] w_rload_addr;
    logic [IDX_W-1:0]      w_ridx;

    assign w_ar_hs      = i_w_arvalid && w_arready;
    assign w_r_hs       = w_rvalid && i_w_rready;
    assign w_ar_bad     = f_burst_bad(i_w_arburst, i_w_arsize, i_w_arlen);
    assign w_rlast_beat = (r_rbeat == r_arlen);

    // The presented beat is pre-fetched: the AR handshake loads beat 0 and each
    // non-final R handshake loads the following beat, so rdata only changes on
    // a handshake and holds through rready stalls.
    assign w_rload_addr = w_ar_hs ? i_w_araddr : f_next_addr(r_raddr, r_arlen, r_arburst);
    assign w_rload_en   = w_ar_hs || (w_r_hs && !w_rlast_beat);
    assign w_rload_err  = (w_ar_hs ? w_ar_bad : r_rbad) || f_oob(w_rload_addr);
    assign w_ridx       = w_rload_addr[BYTE_SHIFT +: IDX_W];

    always_comb begin
        w_rd_next = r_rd_state;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                w_arready = !i_w_areset;
                if (i_w_arvalid && w_arready) w_rd_next = RD_DATA;
            end
            RD_DATA: begin
                w_rvalid = !i_w_areset;
                if (w_rvalid && i_w_rready && w_rlast_beat) w_rd_next = RD_IDLE;
            end
            default: w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_w_aclk) begin
        if (i_w_areset) begin
            r_rd_state <= RD_IDLE;
            r_arid     <= '0;
            r_raddr    <= '0;
            r_arlen    <= '0;
            r_arburst  <= '0;
            r_rbeat    <= '0;
            r_rbad     <= 1'b0;
            r_rerr     <= 1'b0;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                r_arid    <= i_w_arid;
                r_arlen   <= i_w_arlen;
                r_arburst <= i_w_arburst;
                r_rbeat   <= '0;
                r_rbad    <= w_ar_bad;
            end
            if (w_rload_en) begin
                r_raddr <= w_rload_addr;
                r_rerr  <= w_rload_err;
            end
            if (w_r_hs) r_rbeat <= r_rbeat + 8'd1;
        end
    end

    // Storage: not reset. The read samples the old word, so a same-cycle write
    // to the same index is seen by the read only on a later beat.
    always_ff @(posedge i_w_aclk) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (i_w_wstrb[b]) r_mem[w_widx][8*b +: 8] <= i_w_wdata[8*b +: 8];
            end
        end
        if (w_rload_en) r_rdata_raw <= r_mem[w_ridx];
    end

    assign o_w_arready = w_arready;
    assign o_w_rvalid  = w_rvalid;
    assign o_w_rlast   = w_rvalid && w_rlast_beat;
    assign o_w_rresp   = (w_rvalid && r_rerr) ? RESP_SLVERR : RESP_OKAY;
    assign o_w_rid     = w_rvalid ? r_arid : '0;
    assign o_w_rdata   = (w_rvalid && !r_rerr) ? r_rdata_raw : '0;

endmodule
